// File: rtl/rsa_host_sequencer_pkg.sv
// Shared types and constants for the RSA host sequencer: command codes, job modes,
// FSM states and the per-mode command-sequence ROMs.
package rsa_host_sequencer_pkg;

  localparam int unsigned TX_SIZE = 1024;
  localparam int unsigned RES_W   = 512;
  localparam int unsigned CMD_W   = 32;
  localparam int unsigned CODE_W  = 4;
  localparam int unsigned STEP_W  = 3;

  typedef enum logic {
    MODE_EXP  = 1'b0,
    MODE_MONT = 1'b1
  } job_mode_e;

  // Command codes as decoded by the wrapper
  localparam logic [CODE_W-1:0] CMD_MONT_LD_A  = 4'h1;
  localparam logic [CODE_W-1:0] CMD_MONT_LD_B  = 4'h2;
  localparam logic [CODE_W-1:0] CMD_EXP_RUN    = 4'h3;
  localparam logic [CODE_W-1:0] CMD_MONT_RUN   = 4'h4;
  localparam logic [CODE_W-1:0] CMD_EXP_LD_MOD = 4'h5;
  localparam logic [CODE_W-1:0] CMD_EXP_LD_RSQ = 4'h6;
  localparam logic [CODE_W-1:0] CMD_EXP_LD_X   = 4'h7;
  localparam logic [CODE_W-1:0] CMD_READ       = 4'h8;
  localparam logic [CODE_W-1:0] CMD_RESET      = 4'h9;

  typedef enum logic [1:0] {
    WSEL_0    = 2'd0,
    WSEL_1    = 2'd1,
    WSEL_2    = 2'd2,
    WSEL_NONE = 2'd3
  } word_sel_e;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    word_sel_e         wsel;
    logic              is_send;
    logic              is_recv;
    logic              is_last;
  } step_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SEND,
    ST_RECV,
    ST_WAIT_DONE,
    ST_ACK,
    ST_WAIT_DONE_LOW,
    ST_RESULT
  } state_e;

  localparam int unsigned EXP_LEN  = 6;
  localparam int unsigned MONT_LEN = 5;

  // Entries listed from the last step down to step 0
  localparam step_t [EXP_LEN-1:0] EXP_SEQ = {
    step_t'{CMD_READ,       WSEL_NONE, 1'b0, 1'b1, 1'b1},
    step_t'{CMD_EXP_RUN,    WSEL_NONE, 1'b0, 1'b0, 1'b0},
    step_t'{CMD_EXP_LD_X,   WSEL_2,    1'b1, 1'b0, 1'b0},
    step_t'{CMD_EXP_LD_RSQ, WSEL_1,    1'b1, 1'b0, 1'b0},
    step_t'{CMD_EXP_LD_MOD, WSEL_0,    1'b1, 1'b0, 1'b0},
    step_t'{CMD_RESET,      WSEL_NONE, 1'b0, 1'b0, 1'b0}
  };

  localparam step_t [MONT_LEN-1:0] MONT_SEQ = {
    step_t'{CMD_READ,       WSEL_NONE, 1'b0, 1'b1, 1'b1},
    step_t'{CMD_MONT_RUN,   WSEL_NONE, 1'b0, 1'b0, 1'b0},
    step_t'{CMD_MONT_LD_B,  WSEL_1,    1'b1, 1'b0, 1'b0},
    step_t'{CMD_MONT_LD_A,  WSEL_0,    1'b1, 1'b0, 1'b0},
    step_t'{CMD_RESET,      WSEL_NONE, 1'b0, 1'b0, 1'b0}
  };

endpackage

// File: rtl/rsa_host_sequencer_if.sv
// Host-to-wrapper command/data link: command strobe, done handshake and the
// operand (tx) and result (rx) streams.
interface rsa_host_sequencer_if;
  import rsa_host_sequencer_pkg::*;

  logic [CMD_W-1:0]   cmd;
  logic               cmd_valid;
  logic               done;
  logic               done_read;
  logic               tx_valid;
  logic               tx_ready;
  logic [TX_SIZE-1:0] tx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic [TX_SIZE-1:0] rx_data;

  modport master (
    output cmd, cmd_valid, done_read, tx_valid, tx_data, rx_ready,
    input  done, tx_ready, rx_valid, rx_data
  );

  modport slave (
    input  cmd, cmd_valid, done_read, tx_valid, tx_data, rx_ready,
    output done, tx_ready, rx_valid, rx_data
  );
endinterface

// File: rtl/rsa_host_step_rom.sv
// Combinational map from (job mode, step) to the command entry for that step.
module rsa_host_step_rom
  import rsa_host_sequencer_pkg::*;
(
  input  job_mode_e         i_mode,
  input  logic [STEP_W-1:0] i_step,
  output step_t             o_entry_c
);

  // Out-of-range steps decode to an all-zero entry
  always_comb begin
    o_entry_c = '0;
    if (i_mode == MODE_EXP) begin
      if (i_step < STEP_W'(EXP_LEN)) o_entry_c = EXP_SEQ[i_step];
    end else begin
      if (i_step < STEP_W'(MONT_LEN)) o_entry_c = MONT_SEQ[i_step];
    end
  end

endmodule

// File: rtl/rsa_host_sequencer.sv
// Host-side sequencer driving the RSA wrapper through one exp or Montgomery job.
// Optional response timeout: define RSA_HOST_SEQUENCER_TIMEOUT_EN.
module rsa_host_sequencer
  import rsa_host_sequencer_pkg::*;
`ifdef RSA_HOST_SEQUENCER_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 1048576
)
`endif
(
  input  logic                 clk,
  input  logic                 resetn,
  rsa_host_sequencer_if.master wr,
  input  logic                 i_job_valid,
  output logic                 o_job_ready,
  input  logic                 i_job_mode,
  input  logic [TX_SIZE-1:0]   i_job_word0,
  input  logic [TX_SIZE-1:0]   i_job_word1,
  input  logic [TX_SIZE-1:0]   i_job_word2,
  output logic                 o_result_valid,
  input  logic                 i_result_ready,
  output logic [RES_W-1:0]     o_result_data,
  output logic                 o_result_error
);

  state_e             r_state;
  job_mode_e          r_mode;
  logic [STEP_W-1:0]  r_step;
  logic [TX_SIZE-1:0] r_word0;
  logic [TX_SIZE-1:0] r_word1;
  logic [TX_SIZE-1:0] r_word2;
  logic               r_job_ready;
  logic [CMD_W-1:0]   r_cmd;
  logic               r_cmd_valid;
  logic               r_done_read;
  logic               r_tx_valid;
  logic [TX_SIZE-1:0] r_tx_data;
  logic               r_rx_ready;
  logic               r_result_valid;
  logic [RES_W-1:0]   r_result_data;

  step_t              w_entry;
  logic [TX_SIZE-1:0] w_word;
  logic               w_job_take;
  logic               w_unused_rx;

  rsa_host_step_rom u_step_rom (
    .i_mode    (r_mode),
    .i_step    (r_step),
    .o_entry_c (w_entry)
  );

  assign w_job_take  = (r_state == ST_IDLE) && i_job_valid && r_job_ready;
  assign w_unused_rx = ^wr.rx_data[TX_SIZE-1:RES_W];

  always_comb begin
    w_word = '0;
    case (w_entry.wsel)
      WSEL_0:  w_word = r_word0;
      WSEL_1:  w_word = r_word1;
      WSEL_2:  w_word = r_word2;
      default: w_word = '0;
    endcase
  end

`ifdef RSA_HOST_SEQUENCER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_result_error;
  logic             w_in_wait;
  logic             w_tmo_clr;
  logic             w_tmo_hit;

  assign w_in_wait = (r_state == ST_SEND) || (r_state == ST_RECV) ||
                     (r_state == ST_WAIT_DONE) || (r_state == ST_WAIT_DONE_LOW);
  // Exactly the transitions that enter a waiting state
  assign w_tmo_clr = (r_state == ST_ISSUE) || (r_state == ST_ACK) ||
                     ((r_state == ST_SEND) && r_tx_valid && wr.tx_ready) ||
                     ((r_state == ST_RECV) && wr.rx_valid && r_rx_ready);
  assign w_tmo_hit = w_in_wait && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tmo_cnt      <= '0;
      r_result_error <= 1'b0;
    end else begin
      r_tmo_cnt <= w_tmo_clr ? '0 : r_tmo_cnt + TMO_W'(1);
      if (w_job_take)     r_result_error <= 1'b0;
      else if (w_tmo_hit) r_result_error <= 1'b1;
    end
  end

  assign o_result_error = r_result_error;
`else
  assign o_result_error = 1'b0;
`endif

  // Main sequencer; strobes default low and are raised for a single cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state        <= ST_IDLE;
      r_mode         <= MODE_EXP;
      r_step         <= '0;
      r_word0        <= '0;
      r_word1        <= '0;
      r_word2        <= '0;
      r_job_ready    <= 1'b0;
      r_cmd          <= '0;
      r_cmd_valid    <= 1'b0;
      r_done_read    <= 1'b0;
      r_tx_valid     <= 1'b0;
      r_tx_data      <= '0;
      r_rx_ready     <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_data  <= '0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_done_read <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_job_ready <= 1'b1;
          if (w_job_take) begin
            r_mode      <= job_mode_e'(i_job_mode);
            r_word0     <= i_job_word0;
            r_word1     <= i_job_word1;
            r_word2     <= i_job_word2;
            r_step      <= '0;
            r_job_ready <= 1'b0;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cmd       <= CMD_W'(w_entry.code);
          r_cmd_valid <= 1'b1;
          if (w_entry.is_send) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_word;
            r_state    <= ST_SEND;
          end else if (w_entry.is_recv) begin
            r_rx_ready <= 1'b1;
            r_state    <= ST_RECV;
          end else begin
            r_state <= ST_WAIT_DONE;
          end
        end
        ST_SEND: begin
          if (r_tx_valid && wr.tx_ready) begin
            r_tx_valid <= 1'b0;
            r_state    <= ST_WAIT_DONE;
          end
        end
        ST_RECV: begin
          if (wr.rx_valid && r_rx_ready) begin
            r_result_data <= wr.rx_data[RES_W-1:0];
            r_rx_ready    <= 1'b0;
            r_state       <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (wr.done) begin
            r_done_read <= 1'b1;
            r_state     <= ST_ACK;
          end
        end
        ST_ACK: r_state <= ST_WAIT_DONE_LOW;
        ST_WAIT_DONE_LOW: begin
          // Wrapper done is registered, so it lingers one cycle past done_read
          if (!wr.done) begin
            if (w_entry.is_last) begin
              r_result_valid <= 1'b1;
              r_state        <= ST_RESULT;
            end else begin
              r_step  <= r_step + STEP_W'(1);
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_RESULT: begin
          if (i_result_ready) begin
            r_result_valid <= 1'b0;
            r_job_ready    <= 1'b1;
            r_state        <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
`ifdef RSA_HOST_SEQUENCER_TIMEOUT_EN
      if (w_tmo_hit) begin
        r_tx_valid     <= 1'b0;
        r_rx_ready     <= 1'b0;
        r_done_read    <= 1'b0;
        r_result_data  <= '0;
        r_result_valid <= 1'b1;
        r_state        <= ST_RESULT;
      end
`endif
    end
  end

  assign o_job_ready    = r_job_ready;
  assign o_result_valid = r_result_valid;
  assign o_result_data  = r_result_data;
  assign wr.cmd         = r_cmd;
  assign wr.cmd_valid   = r_cmd_valid;
  assign wr.done_read   = r_done_read;
  assign wr.tx_valid    = r_tx_valid;
  assign wr.tx_data     = r_tx_data;
  assign wr.rx_ready    = r_rx_ready;

endmodule

// File: tb/tb_rsa_host_sequencer.sv
// Bench for rsa_host_sequencer: behavioural wrapper responder plus directed and
// randomized jobs checked against the expected command/operand/result trace.
module tb_rsa_host_sequencer;

  logic          clk;
  logic          resetn;
  logic          job_valid;
  logic          job_ready;
  logic          job_mode;
  logic [1023:0] job_w0, job_w1, job_w2;
  logic          result_valid;
  logic          result_ready;
  logic [511:0]  result_data;
  logic          result_error;

  rsa_host_sequencer_if bus ();

`ifdef RSA_HOST_SEQUENCER_TIMEOUT_EN
  rsa_host_sequencer #(.TIMEOUT_CYCLES(16)) dut (
`else
  rsa_host_sequencer dut (
`endif
    .clk            (clk),
    .resetn         (resetn),
    .wr             (bus),
    .i_job_valid    (job_valid),
    .o_job_ready    (job_ready),
    .i_job_mode     (job_mode),
    .i_job_word0    (job_w0),
    .i_job_word1    (job_w1),
    .i_job_word2    (job_w2),
    .o_result_valid (result_valid),
    .i_result_ready (result_ready),
    .o_result_data  (result_data),
    .o_result_error (result_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    logic [255:0] o_lo, e_lo;
    o_lo = obs[255:0];
    e_lo = exp[255:0];
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o_lo, e_lo);
    end
  endtask

  // Wrapper responder configuration and logs
  int            cfg_tx_delay   = -1;
  int            cfg_done_delay = -1;
  int            cfg_done_hold  = -1;
  bit            cfg_done_never = 1'b0;
  logic [1023:0] cfg_rx_word    = '0;
  int            cmd_log[$];
  logic [1023:0] tx_log[$];
  int            ack_cnt = 0;
  int            m_phase = 0;
  int            m_cnt   = 0;
  logic [1023:0] m_word;

  // Behavioural wrapper: acts on DUT outputs at the falling edge
  always @(negedge clk) begin
    if (!resetn) begin
      m_phase      = 0;
      bus.done     = 1'b0;
      bus.tx_ready = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = '0;
    end else begin
      case (m_phase)
        0: if (bus.cmd_valid) begin
          cmd_log.push_back(int'(bus.cmd));
          if (bus.cmd inside {32'd1, 32'd2, 32'd5, 32'd6, 32'd7}) begin
            m_cnt   = (cfg_tx_delay < 0) ? int'($urandom_range(0, 5)) : cfg_tx_delay;
            m_word  = bus.tx_data;
            m_phase = 1;
          end else if (bus.cmd == 32'd8) begin
            check("rx_ready_up", 1024'(bus.rx_ready), 1024'(1));
            bus.rx_valid = 1'b1;
            bus.rx_data  = cfg_rx_word;
            m_phase      = 2;
          end else begin
            m_cnt   = (cfg_done_delay < 0) ? int'($urandom_range(0, 3)) : cfg_done_delay;
            m_phase = 3;
          end
        end
        1: begin
          check("tx_hold_valid", 1024'(bus.tx_valid), 1024'(1));
          check("tx_hold_data", bus.tx_data, m_word);
          if (m_cnt == 0) begin
            bus.tx_ready = 1'b1;
            tx_log.push_back(bus.tx_data);
            m_phase = 5;
          end else m_cnt--;
        end
        5: begin
          bus.tx_ready = 1'b0;
          check("tx_drop", 1024'(bus.tx_valid), 1024'(0));
          m_cnt   = (cfg_done_delay < 0) ? int'($urandom_range(0, 3)) : cfg_done_delay;
          m_phase = 3;
        end
        2: begin
          check("rx_drop", 1024'(bus.rx_ready), 1024'(0));
          bus.rx_valid = 1'b0;
          m_cnt   = (cfg_done_delay < 0) ? int'($urandom_range(0, 3)) : cfg_done_delay;
          m_phase = 3;
        end
        3: if (!cfg_done_never) begin
          if (m_cnt == 0) begin
            bus.done = 1'b1;
            m_phase  = 4;
          end else m_cnt--;
        end
        4: if (bus.done_read) begin
          ack_cnt++;
          m_cnt   = (cfg_done_hold < 0) ? int'($urandom_range(0, 3)) : cfg_done_hold;
          m_phase = 6;
        end
        6: begin
          if (m_cnt == 0) begin
            bus.done = 1'b0;
            m_phase  = 0;
          end else begin
            check("no_double_ack", 1024'(bus.done_read), 1024'(0));
            check("no_cmd_while_done", 1024'(bus.cmd_valid), 1024'(0));
            m_cnt--;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  function automatic logic [1023:0] rand_word();
    logic [1023:0] w;
    for (int i = 0; i < 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic start_job(input logic mode, input logic [1023:0] w0, w1, w2);
    int n;
    n = 0;
    while (!job_ready && n < 50) begin @(negedge clk); n++; end
    check("job_ready_idle", 1024'(job_ready), 1024'(1));
    job_mode  = mode;
    job_w0    = w0;
    job_w1    = w1;
    job_w2    = w2;
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    check("job_ready_busy", 1024'(job_ready), 1024'(0));
  endtask

  // One complete job; expectations derived from the mode's command list
  task automatic run_job(input logic mode, input logic [1023:0] w0, w1, w2, rxw,
                         input int rdy_delay);
    int            exp_cmds[$];
    logic [1023:0] exp_tx[$];
    logic [511:0]  exp_res;
    int            cyc, ncmd;
    if (mode == 1'b0) begin
      exp_cmds = '{9, 5, 6, 7, 3, 8};
      exp_tx   = '{w0, w1, w2};
    end else begin
      exp_cmds = '{9, 1, 2, 4, 8};
      exp_tx   = '{w0, w1};
    end
    exp_res = rxw[511:0];
    cmd_log.delete();
    tx_log.delete();
    ack_cnt     = 0;
    cfg_rx_word = rxw;
    start_job(mode, w0, w1, w2);
    cyc = 0;
    while (!result_valid && cyc < 3000) begin @(negedge clk); cyc++; end
    check("result_arrive", 1024'(result_valid), 1024'(1));
    if (result_valid) begin
      ncmd = cmd_log.size();
      job_valid = 1'b1;
      for (int i = 0; i < rdy_delay; i++) begin
        @(negedge clk);
        check("result_hold_valid", 1024'(result_valid), 1024'(1));
        check("result_hold_data", 1024'(result_data), 1024'(exp_res));
        check("job_ready_in_result", 1024'(job_ready), 1024'(0));
      end
      job_valid = 1'b0;
      check("job_ignored", 1024'(cmd_log.size()), 1024'(ncmd));
      check("result_data", 1024'(result_data), 1024'(exp_res));
      check("result_error", 1024'(result_error), 1024'(0));
      check("cmd_count", 1024'(cmd_log.size()), 1024'(exp_cmds.size()));
      for (int i = 0; i < exp_cmds.size() && i < cmd_log.size(); i++)
        check($sformatf("cmd_%0d", i), 1024'(cmd_log[i]), 1024'(exp_cmds[i]));
      check("tx_count", 1024'(tx_log.size()), 1024'(exp_tx.size()));
      for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
        check($sformatf("tx_word_%0d", i), tx_log[i], exp_tx[i]);
      check("ack_count", 1024'(ack_cnt), 1024'(exp_cmds.size()));
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      check("result_clear", 1024'(result_valid), 1024'(0));
      check("job_ready_back", 1024'(job_ready), 1024'(1));
    end
  endtask

  initial begin
    int n;
    logic [1023:0] rw;
    resetn       = 1'b0;
    job_valid    = 1'b0;
    job_mode     = 1'b0;
    job_w0       = '0;
    job_w1       = '0;
    job_w2       = '0;
    result_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_job_ready", 1024'(job_ready), 1024'(0));
    check("rst_cmd", 1024'(bus.cmd), 1024'(0));
    check("rst_cmd_valid", 1024'(bus.cmd_valid), 1024'(0));
    check("rst_tx_valid", 1024'(bus.tx_valid), 1024'(0));
    check("rst_rx_ready", 1024'(bus.rx_ready), 1024'(0));
    check("rst_result_valid", 1024'(result_valid), 1024'(0));
    check("rst_result_data", 1024'(result_data), 1024'(0));
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_job_ready", 1024'(job_ready), 1024'(1));

    // Montgomery a=3, b=5, m=7
    rw = rand_word();
    rw[511:0] = 512'h0ABC;
    run_job(1'b1, {512'd3, 512'd5}, {512'd0, 512'd7}, '0, rw, 4);

    // Exponentiation returning 0x1234
    run_job(1'b0, rand_word(), rand_word(), rand_word(), 1024'h1234, 1);

    // Operand ready stalled for 5 cycles
    cfg_tx_delay = 5;
    run_job(1'b1, rand_word(), rand_word(), '0, rand_word(), 0);
    cfg_tx_delay = -1;

    // done lingering for 3 cycles after each acknowledge
    cfg_done_hold = 3;
    run_job(1'b0, rand_word(), rand_word(), rand_word(), rand_word(), 2);
    cfg_done_hold = -1;

    for (int j = 0; j < 4; j++)
      run_job(1'($urandom_range(0, 1)), rand_word(), rand_word(), rand_word(), rand_word(),
              int'($urandom_range(0, 3)));

    // Reset while command 6 waits on tx_ready
    cfg_tx_delay = 200;
    cmd_log.delete();
    start_job(1'b0, rand_word(), rand_word(), rand_word());
    n = 0;
    while (!(cmd_log.size() == 3 && m_phase == 1) && n < 500) begin @(negedge clk); n++; end
    check("midjob_reach_cmd6", 1024'(cmd_log.size() == 3 && m_phase == 1), 1024'(1));
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_job_ready", 1024'(job_ready), 1024'(0));
    check("midrst_cmd", 1024'(bus.cmd), 1024'(0));
    check("midrst_tx_valid", 1024'(bus.tx_valid), 1024'(0));
    check("midrst_tx_data", bus.tx_data, 1024'(0));
    check("midrst_done_read", 1024'(bus.done_read), 1024'(0));
    check("midrst_result_valid", 1024'(result_valid), 1024'(0));
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    cfg_tx_delay = -1;
    run_job(1'b0, rand_word(), rand_word(), rand_word(), rand_word(), 1);

`ifdef RSA_HOST_SEQUENCER_TIMEOUT_EN
    // done never arrives for command 9
    cfg_done_never = 1'b1;
    start_job(1'b1, rand_word(), rand_word(), '0);
    n = 0;
    while (!bus.cmd_valid && n < 50) begin @(negedge clk); n++; end
    check("tmo_cmd_seen", 1024'(bus.cmd_valid), 1024'(1));
    n = 0;
    while (!result_valid && n < 100) begin @(negedge clk); n++; end
    check("tmo_cycles", 1024'(n), 1024'(16));
    check("tmo_error", 1024'(result_error), 1024'(1));
    check("tmo_data", 1024'(result_data), 1024'(0));
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("tmo_clear", 1024'(result_valid), 1024'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
